cla_adder_pipe: RTL and testbench
=================================

// Module: cla_adder_pipe
// PURPOSE
//  Parametrised, pipelined two-level carry-lookahead adder/subtractor for the CPU ALU datapath.
//  Splits WIDTH into GROUP-bit lookahead groups; the group carry chain is cut into STAGES register stages.
//  Valid/ready handshake on both sides; returns sum, carry-out, signed overflow and zero flags.
// PARAMETERS
//  WIDTH   32  operand/result width in bits
//  GROUP   4   bits per lookahead group (first-level CLA size)
//  STAGES  2   pipeline register stages (= latency); legal 1..WIDTH/GROUP
// PORTS
//  clk        in   1      clock, all state on rising edge
//  rst_n      in   1      reset, synchronous, active-low
//  in_valid   in   1      operand set presented
//  in_ready   out  1      block accepts operands this cycle
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  c_in       in   1      carry-in (add only; ignored when sub=1)
//  sub        in   1      1: A - B computed as A + ~B + 1
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer takes result this cycle
//  sum        out  WIDTH  result
//  c_out      out  1      carry out of MSB (sub: 1 = no borrow)
//  overflow   out  1      signed overflow: carry into MSB XOR carry out of MSB
//  zero       out  1      sum == 0
// BEHAVIOUR
//  - Elaboration check: WIDTH % GROUP == 0 and (WIDTH/GROUP) % STAGES == 0, else $error.
//  - NG = WIDTH/GROUP groups; GPS = NG/STAGES groups per stage. Stage k resolves groups k*GPS..k*GPS+GPS-1
//    using group P/G (second-level lookahead within stage), carry entering from stage k-1's register.
//  - Per-stage register: valid bit, remaining operand bits, partial sum so far, carry into next group.
//  - Global advance: adv = !out_valid | out_ready; in_ready = adv (combinational, no in_valid dependency).
//  - Transfer in when in_valid & in_ready; a stage shifts only when adv=1; when adv=0 every stage holds.
//  - Bubbles are not collapsed: a stage with valid=0 still shifts as an empty slot when adv=1.
//  - Latency exactly STAGES cycles from accept to out_valid with out_ready held high; throughput 1/cycle.
//  - Results leave in acceptance order; no result dropped or duplicated under any out_ready pattern.
//  - While out_valid=1 & out_ready=0: sum, c_out, overflow, zero stable.
//  - Flags registered with sum in last stage; all four outputs come straight from flops.
//  - sub=1: b inverted and carry-in forced to 1 at stage-0 entry; c_in ignored.
//  - Reset (rst_n=0 at clk edge): all stage valids 0; sum=0, c_out=0, overflow=0, zero=0, out_valid=0;
//    in_ready=1 in the cycle after reset; in-flight operations discarded, none appear after release.
//  - Reset wins over simultaneous accept: an operand offered in the reset cycle is dropped.
// STRUCTURE
//  - Shared package/header cla_defs: localparams for default WIDTH/GROUP, sub-mode encoding.
//  - Sub-module cla_group #(GROUP): combinational P/G -> per-bit carries + group Gm/Pm;
//    instantiated NG times via generate; second-level lookahead built per stage over GPS groups.
//  - Top holds pipeline registers, handshake logic and flag generation only.
// TESTING  (WIDTH=32, GROUP=4, STAGES=2)
//  - a=FFFFFFFF b=00000001 c_in=0 sub=0 -> 2 cycles later sum=00000000 c_out=1 zero=1 overflow=0.
//  - a=80000000 b=00000001 sub=1 -> sum=7FFFFFFF c_out=1 overflow=1 zero=0.
//  - a=7FFFFFFF b=7FFFFFFF c_in=1 -> sum=FFFFFFFF c_out=0 overflow=1; c_in=1 with sub=1 on 5-5 -> sum=0.
//  - 4 back-to-back ops (1+1,2+2,3+3,4+4), out_ready=1 -> out_valid cycles 2..5, sums 2,4,6,8 in order.
//  - Pipeline full, out_ready=0 for 3 cycles -> in_ready=0, outputs frozen; release -> all queued results, none lost.
//  - rst_n=0 for one cycle with 2 ops in flight -> out_valid=0, sum=0 next cycle; no stale result afterwards.

Source files
------------

// File: rtl/cla_adder_pipe_pkg.sv
// cla_adder_pipe_pkg: shared defaults and operation encoding for the pipelined CLA adder
package cla_adder_pipe_pkg;
    localparam int CLA_WIDTH  = 32;
    localparam int CLA_GROUP  = 4;
    localparam int CLA_STAGES = 2;
    typedef enum logic { OP_ADD = 1'b0, OP_SUB = 1'b1 } op_e;
    function automatic logic entry_carry(op_e op, logic c_in);
        return (op == OP_SUB) | c_in;
    endfunction
endpackage

// File: rtl/cla_adder_pipe_group.sv
// cla_group: first-level lookahead group producing sum bits and group generate/propagate
module cla_group #(
    parameter int GROUP = 4
) (
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             ci,
    output logic [GROUP-1:0] s,
    output logic             gm,
    output logic             pm
);
    logic [GROUP-1:0] gen, prop, c;
    assign gen  = a & b;
    assign prop = a ^ b;
    assign s    = prop ^ c;
    assign pm   = &prop;
    always_comb begin
        c[0] = ci;
        for (int i = 1; i < GROUP; i++) c[i] = gen[i-1] | (prop[i-1] & c[i-1]);
    end
    always_comb begin
        gm = 1'b0;
        for (int i = 0; i < GROUP; i++) gm = gen[i] | (prop[i] & gm);
    end
endmodule

// File: rtl/cla_adder_pipe.sv
// cla_adder_pipe: pipelined two-level carry-lookahead adder/subtractor with valid/ready handshake
module cla_adder_pipe
    import cla_adder_pipe_pkg::*;
#(
    parameter int WIDTH  = CLA_WIDTH,
    parameter int GROUP  = CLA_GROUP,
    parameter int STAGES = CLA_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow,
    output logic             zero
);
    localparam int NG  = WIDTH / GROUP;
    localparam int GPS = NG / STAGES;
    localparam int SW  = GPS * GROUP;
    logic             adv, c_msb;
    op_e              op;
    logic [STAGES-1:0] vld, cy, st_v, st_c, st_co;
    logic [WIDTH-1:0] op_a [STAGES];
    logic [WIDTH-1:0] op_b [STAGES];
    logic [WIDTH-1:0] ps [STAGES];
    logic [WIDTH-1:0] st_a [STAGES];
    logic [WIDTH-1:0] st_b [STAGES];
    logic [WIDTH-1:0] nxt_ps [STAGES];
    logic [NG-1:0]    gm, pm, gc;
    logic [WIDTH-1:0] grp_s;
    assign op        = op_e'(sub);
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;
    assign out_valid = vld[STAGES-1];
    assign sum       = ps[STAGES-1];
    assign c_out     = cy[STAGES-1];
    assign c_msb     = st_a[STAGES-1][WIDTH-1] ^ st_b[STAGES-1][WIDTH-1] ^ grp_s[WIDTH-1];
    if (WIDTH % GROUP != 0 || (WIDTH / GROUP) % STAGES != 0) begin : g_bad_cfg
        $error("cla_adder_pipe: illegal WIDTH/GROUP/STAGES combination");
    end
    for (genvar g = 0; g < NG; g++) begin : g_grp
        cla_group #(.GROUP(GROUP)) u_grp (
            .a  (st_a[g/GPS][g*GROUP +: GROUP]),
            .b  (st_b[g/GPS][g*GROUP +: GROUP]),
            .ci (gc[g]),
            .s  (grp_s[g*GROUP +: GROUP]),
            .gm (gm[g]),
            .pm (pm[g])
        );
    end
    // second-level lookahead: each group carry as a flat sum of products over its stage
    always_comb begin
        logic acc, term;
        gc    = '0;
        st_co = '0;
        for (int s = 0; s < STAGES; s++)
            for (int j = 0; j <= GPS; j++) begin
                acc = st_c[s];
                for (int k = 0; k < j; k++) acc &= pm[s*GPS+k];
                for (int i = 0; i < j; i++) begin
                    term = gm[s*GPS+i];
                    for (int k = i + 1; k < j; k++) term &= pm[s*GPS+k];
                    acc |= term;
                end
                if (j < GPS) gc[s*GPS+j] = acc;
                else st_co[s] = acc;
            end
    end
    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int LO = s * SW;
        if (s == 0) begin : g_head
            assign st_v[s] = in_valid;
            assign st_a[s] = a;
            assign st_b[s] = op == OP_SUB ? ~b : b;
            assign st_c[s] = entry_carry(op, c_in);
        end else begin : g_body
            assign st_v[s] = vld[s-1];
            assign st_a[s] = op_a[s-1];
            assign st_b[s] = op_b[s-1];
            assign st_c[s] = cy[s-1];
            assign nxt_ps[s][LO-1:0] = ps[s-1][LO-1:0];
        end
        assign nxt_ps[s][LO +: SW] = grp_s[LO +: SW];
        if (s < STAGES - 1) begin : g_upper
            assign nxt_ps[s][WIDTH-1:LO+SW] = '0;
        end
        always_ff @(posedge clk)
            if (!rst_n) begin
                vld[s] <= 1'b0;
                ps[s]  <= '0;
                cy[s]  <= 1'b0;
            end else if (adv) begin
                vld[s] <= st_v[s];
                if (st_v[s]) begin
                    op_a[s] <= st_a[s];
                    op_b[s] <= st_b[s];
                    ps[s]   <= nxt_ps[s];
                    cy[s]   <= st_co[s];
                end
            end
    end
    always_ff @(posedge clk)
        if (!rst_n) begin
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else if (adv && st_v[STAGES-1]) begin
            overflow <= c_msb ^ st_co[STAGES-1];
            zero     <= nxt_ps[STAGES-1] == '0;
        end
endmodule

// File: tb/tb_cla_adder_pipe.sv
// tb_cla_adder_pipe: table vectors, handshake corner sequences and randomized scoreboard for cla_adder_pipe
module tb_cla_adder_pipe;
    typedef struct packed {
        logic [31:0] sum;
        logic        c;
        logic        ovf;
        logic        zero;
    } res_t;
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        res_t        exp;
    } vec_t;
    logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, c_in = 1'b0, sub = 1'b0, out_ready = 1'b1;
    logic [31:0] a = '0, b = '0;
    logic in_ready, out_valid, c_out, overflow, zero;
    logic [31:0] sum;
    int checks = 0, errors = 0;
    res_t q[$];
    res_t held;
    logic held_ok = 1'b0;
    vec_t vecs[10];
    always #5 clk = ~clk;
    cla_adder_pipe #(.WIDTH(32), .GROUP(4), .STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c_in(c_in), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .c_out(c_out), .overflow(overflow), .zero(zero)
    );
    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask
    function automatic res_t model(input logic [31:0] x, input logic [31:0] y, input logic ci, input logic s);
        res_t r;
        longint sr;
        logic [32:0] u;
        if (s) begin
            sr    = longint'($signed(x)) - longint'($signed(y));
            r.sum = x - y;
            r.c   = x >= y;
        end else begin
            sr    = longint'($signed(x)) + longint'($signed(y)) + longint'(ci);
            u     = 33'(x) + 33'(y) + 33'(ci);
            r.sum = u[31:0];
            r.c   = u[32];
        end
        r.ovf  = sr > 64'sd2147483647 || sr < -64'sd2147483648;
        r.zero = r.sum == 32'h0;
        return r;
    endfunction
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic drive(input logic v, input logic [31:0] x, input logic [31:0] y, input logic ci, input logic s);
        in_valid = v; a = x; b = y; c_in = ci; sub = s;
    endtask
    task automatic run_vec(input vec_t v);
        int n;
        tick();
        out_ready = 1'b1;
        drive(1'b1, v.a, v.b, v.cin, v.sub);
        tick();
        in_valid = 1'b0;
        n = 0;
        while (n < 8) begin
            @(negedge clk);
            n++;
            if (out_valid) break;
        end
        chk("vec_latency", 64'(n), 64'd2);
        chk("vec_result", {sum, c_out, overflow, zero}, v.exp);
    endtask
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            held_ok = 1'b0;
        end else begin
            chk("in_ready_rule", in_ready, !out_valid || out_ready);
            if (held_ok) begin
                chk("hold_valid", out_valid, 1'b1);
                chk("hold_outputs", {sum, c_out, overflow, zero}, held);
            end
            held_ok = out_valid && !out_ready;
            held    = {sum, c_out, overflow, zero};
            if (out_valid && out_ready) begin
                chk("result_expected", q.size() != 0, 1'b1);
                if (q.size() != 0) chk("result_order", {sum, c_out, overflow, zero}, q.pop_front());
            end
            if (in_valid && in_ready) q.push_back(model(a, b, c_in, sub));
        end
    end
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
    initial begin
        logic [6:0]  ev;
        logic [31:0] es [7];
        int n;
        vecs[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, {32'h00000000, 1'b1, 1'b0, 1'b1}};
        vecs[1] = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, {32'h7FFFFFFF, 1'b1, 1'b1, 1'b0}};
        vecs[2] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 1'b0, {32'hFFFFFFFF, 1'b0, 1'b1, 1'b0}};
        vecs[3] = '{32'h00000005, 32'h00000005, 1'b1, 1'b1, {32'h00000000, 1'b1, 1'b0, 1'b1}};
        vecs[4] = '{32'h00000000, 32'h00000000, 1'b1, 1'b0, {32'h00000001, 1'b0, 1'b0, 1'b0}};
        vecs[5] = '{32'h00000000, 32'h00000001, 1'b0, 1'b1, {32'hFFFFFFFF, 1'b0, 1'b0, 1'b0}};
        vecs[6] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, {32'h00000000, 1'b1, 1'b1, 1'b1}};
        vecs[7] = '{32'hFFFF0000, 32'h0000FFFF, 1'b1, 1'b0, {32'h00000000, 1'b1, 1'b0, 1'b1}};
        vecs[8] = '{32'h00000010, 32'h00000020, 1'b0, 1'b1, {32'hFFFFFFF0, 1'b0, 1'b0, 1'b0}};
        vecs[9] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, {32'h80000000, 1'b0, 1'b1, 1'b0}};
        // power-on reset: flags clear even though sum reads zero
        tick();
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_sum", sum, 32'h0);
        chk("reset_c_out", c_out, 1'b0);
        chk("reset_overflow", overflow, 1'b0);
        chk("reset_zero", zero, 1'b0);
        chk("reset_in_ready", in_ready, 1'b1);
        for (int i = 0; i < 10; i++) run_vec(vecs[i]);
        // back-to-back 1+1..4+4, results on cycles 2..5
        tick();
        out_ready = 1'b1;
        ev = 7'b0111100;
        es = '{0, 0, 2, 4, 6, 8, 0};
        for (int c = 0; c < 7; c++) begin
            if (c < 4) drive(1'b1, 32'(c + 1), 32'(c + 1), 1'b0, 1'b0);
            else in_valid = 1'b0;
            @(negedge clk);
            chk("b2b_valid", out_valid, ev[c]);
            if (ev[c]) chk("b2b_sum", sum, es[c]);
            tick();
        end
        // fill pipe with consumer stalled, then release
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 32'(10 * (c + 1)), 32'h0, 1'b0, 1'b0);
            @(negedge clk);
            if (c < 2) tick();
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_in_ready", in_ready, 1'b0);
            chk("stall_valid", out_valid, 1'b1);
            chk("stall_sum", sum, 32'd10);
            tick();
        end
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("release_valid", out_valid, 1'b1);
            chk("release_sum", sum, 32'(10 * (k + 1)));
            tick();
            in_valid = 1'b0;
        end
        @(negedge clk);
        chk("release_empty", out_valid, 1'b0);
        // reset with two ops in flight and a third offered during reset
        tick();
        drive(1'b1, 32'd7, 32'd7, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'd9, 32'd9, 1'b0, 1'b0);
        tick();
        rst_n = 1'b0;
        drive(1'b1, 32'd11, 32'd11, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("midreset_valid", out_valid, 1'b0);
        chk("midreset_sum", sum, 32'h0);
        chk("midreset_in_ready", in_ready, 1'b1);
        for (int k = 0; k < 5; k++) begin
            tick();
            @(negedge clk);
            chk("midreset_no_stale", out_valid, 1'b0);
        end
        // randomized traffic against the scoreboard
        tick();
        for (int k = 0; k < 400; k++) begin
            drive($urandom_range(0, 3) != 0,
                  $urandom_range(0, 7) == 0 ? 32'hFFFFFFFF : $urandom,
                  $urandom_range(0, 7) == 0 ? 32'h0 : $urandom,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            out_ready = $urandom_range(0, 3) != 0;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        chk("drain_empty", 64'(q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
